// File: rtl/detector_jogada_pkg.sv
// -----------------------------------------------------------------------------
// detector_jogada_pkg
// Shared definitions for the jogada (key press) detector:
//   - FSM state encodings (ESPERA, SEGURA), also shown on the debug display
//   - default debounce length in clock cycles
//   - one-hot test used to validate a debounced switch vector
// -----------------------------------------------------------------------------
package detector_jogada_pkg;

    // FSM encodings; the 2-bit value is exported as db_estado.
    localparam logic [1:0] ESPERA = 2'b00;  // waiting for a press
    localparam logic [1:0] SEGURA = 2'b01;  // press consumed, waiting for release

    // 4 samples at 1 kHz gives 4 ms of debounce.
    localparam int DEBOUNCE_CICLOS_PADRAO = 4;

    // True when exactly one bit is set. Callers zero-extend narrower vectors,
    // which does not change the answer.
    function automatic logic eh_one_hot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/filtro_debounce.sv
// -----------------------------------------------------------------------------
// filtro_debounce
// Two-flop synchroniser followed by a vector-wide debounce filter. A new switch
// value is accepted into deb only after the synchronised vector has matched
// the candidate for DEBOUNCE_CICLOS consecutive evaluations after it was
// captured, so any change shorter than DEBOUNCE_CICLOS+1 samples is dropped.
//
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous reset, active low
//   chaves      in   raw asynchronous switches [N_CHAVES]
//   deb         out  debounced switch vector [N_CHAVES]
//   tem_jogada  out  registered (deb != 0), updated together with deb
// -----------------------------------------------------------------------------
module filtro_debounce #(
    parameter int N_CHAVES        = 4,
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_CHAVES-1:0] chaves,
    output logic [N_CHAVES-1:0] deb,
    output logic                tem_jogada
);

    // DEBOUNCE_CICLOS >= 2 keeps the counter at least one bit wide.
    localparam int                CNT_W   = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic [N_CHAVES-1:0] r_sync1;
    logic [N_CHAVES-1:0] r_sync2;
    logic [N_CHAVES-1:0] r_candidato;
    logic [N_CHAVES-1:0] r_deb;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_tem;

    // NOTE: non-blocking assignments make every flop sample the pre-edge
    // value of its source, which is what turns r_sync1 -> r_sync2 into a
    // two-stage chain instead of a single wire.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_candidato <= '0;
            r_deb       <= '0;
            r_cnt       <= '0;
            r_tem       <= 1'b0;
        end else begin
            r_sync1 <= chaves;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_candidato) begin
                // Input moved: restart the stability window on the new value.
                r_candidato <= r_sync2;
                r_cnt       <= '0;
            end else if (r_cnt == CNT_MAX) begin
                // Stable long enough; the counter saturates here.
                r_deb <= r_candidato;
                r_tem <= (r_candidato != '0);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign deb        = r_deb;
    assign tem_jogada = r_tem;

endmodule

// File: rtl/detector_jogada.sv
// -----------------------------------------------------------------------------
// detector_jogada
// Input stage of the memory game: debounces the switch vector, validates that
// exactly one key is pressed, pulses jogada_feita / jogada_invalida once per
// physical press and holds the last accepted one-hot code.
//
// Ports:
//   clock            in   system clock (1 kHz nominal)
//   reset            in   asynchronous reset, active low
//   chaves           in   raw switches [N_CHAVES]
//   habilita         in   press is accepted only while high
//   limpa            in   synchronous clear of jogada (acceptance wins)
//   jogada_feita     out  one-cycle pulse on a valid one-hot press
//   jogada_invalida  out  one-cycle pulse on a non-one-hot press
//   jogada           out  last accepted code [N_CHAVES]
//   tem_jogada       out  debounced vector is nonzero
//   db_estado        out  FSM state for the debug display
// -----------------------------------------------------------------------------
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int N_CHAVES        = 4,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_CHAVES-1:0] chaves,
    input  logic                habilita,
    input  logic                limpa,
    output logic                jogada_feita,
    output logic                jogada_invalida,
    output logic [N_CHAVES-1:0] jogada,
    output logic                tem_jogada,
    output logic [1:0]          db_estado
);

    logic [N_CHAVES-1:0] w_deb;
    logic                w_tem;
    logic [1:0]          r_estado;
    logic [1:0]          w_prox_estado;
    logic                w_aceita;
    logic                w_invalida;
    logic [N_CHAVES-1:0] r_jogada;

    filtro_debounce #(
        .N_CHAVES        (N_CHAVES),
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
    ) u_filtro (
        .clock      (clock),
        .reset      (reset),
        .chaves     (chaves),
        .deb        (w_deb),
        .tem_jogada (w_tem)
    );

    // Pulses are decoded from ESPERA and the current deb, so they rise in the
    // same cycle deb takes the new value; leaving ESPERA at the next edge is
    // what limits them to one cycle.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_prox_estado = r_estado;
        w_aceita      = 1'b0;
        w_invalida    = 1'b0;
        case (r_estado)
            ESPERA: begin
                if (w_deb != '0) begin
                    // The press is consumed even when habilita is low.
                    w_prox_estado = SEGURA;
                    if (habilita) begin
                        if (eh_one_hot(32'(w_deb))) w_aceita   = 1'b1;
                        else                        w_invalida = 1'b1;
                    end
                end
            end
            SEGURA: begin
                // Key changes while held are ignored until full release.
                if (w_deb == '0) w_prox_estado = ESPERA;
            end
            default: w_prox_estado = ESPERA;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= ESPERA;
            r_jogada <= '0;
        end else begin
            r_estado <= w_prox_estado;
            if (w_aceita)   r_jogada <= w_deb;
            else if (limpa) r_jogada <= '0;
        end
    end

    assign jogada_feita    = w_aceita;
    assign jogada_invalida = w_invalida;
    assign jogada          = r_jogada;
    assign tem_jogada      = w_tem;
    assign db_estado       = r_estado;

endmodule
